// File: rtl/mem_arb.sv
// mem_arb: three-way round-robin burst arbiter with starvation override.
// Optional state-coverage map is built when MEM_ARB_COV_EN is defined.
module mem_arb #(
  parameter int unsigned BEATS    = 2,
  parameter int unsigned MAX_WAIT = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       meta_reset,
  input  logic [2:0] req_valid,
  input  logic [3:0] req0_data,
  input  logic [3:0] req1_data,
  input  logic [3:0] req2_data,
  output logic [2:0] req_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic [1:0] out_src,
  input  logic       out_ready,
  output logic       starve,
  output logic       aborted,
  output logic [5:0] coverage
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  state_e            state_q, state_d;
  logic [1:0]        g_q, g_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        beat_q, beat_d;
  logic [2:0][3:0]   wait_q, wait_d;
  logic              aborted_q, aborted_d;

  logic [2:0]        sat;
  logic [1:0]        rr1, rr2, pick;
  logic              sel_valid;
  logic [3:0]        sel_data;

  function automatic logic [1:0] next_idx(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign sat = {wait_q[2] == WAIT_MAX, wait_q[1] == WAIT_MAX, wait_q[0] == WAIT_MAX};

  // Starvation override first, then round-robin ptr+1, ptr+2, ptr.
  always_comb begin
    rr1  = next_idx(ptr_q);
    rr2  = next_idx(rr1);
    pick = ptr_q;
    if (sat[0])                 pick = 2'd0;
    else if (sat[1])            pick = 2'd1;
    else if (sat[2])            pick = 2'd2;
    else if (req_valid[rr1])    pick = rr1;
    else if (req_valid[rr2])    pick = rr2;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    case (g_q)
      2'd0: begin sel_valid = req_valid[0]; sel_data = req0_data; end
      2'd1: begin sel_valid = req_valid[1]; sel_data = req1_data; end
      2'd2: begin sel_valid = req_valid[2]; sel_data = req2_data; end
      default: ;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    req_ready = '0;
    if (state_q == BURST) begin
      out_valid      = sel_valid;
      out_data       = sel_data;
      req_ready[g_q] = out_ready;
    end
  end

  assign out_src = g_q;
  assign starve  = |sat;
  assign aborted = aborted_q;

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    ptr_d     = ptr_q;
    beat_d    = beat_q;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = BURST;
          g_d     = pick;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (!sel_valid) begin
          state_d   = GAP;
          aborted_d = 1'b1;
        end else if (out_ready) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) state_d = GAP;
        end
      end
      GAP: begin
        ptr_d   = g_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Waiting accrues only during arbitration and while another requester
  // is bursting; the GAP cycle holds every counter.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      wait_d[i] = wait_q[i];
      if (!req_valid[i]) begin
        wait_d[i] = '0;
      end else if (state_q == IDLE && pick == 2'(i)) begin
        wait_d[i] = '0;
      end else if ((state_q == IDLE || (state_q == BURST && g_q != 2'(i)))
                   && wait_q[i] < WAIT_MAX) begin
        wait_d[i] = wait_q[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      g_q       <= '0;
      ptr_q     <= 2'd2;
      beat_q    <= '0;
      wait_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      ptr_q     <= ptr_d;
      beat_q    <= beat_d;
      wait_q    <= wait_d;
      aborted_q <= aborted_d;
    end
  end

`ifdef MEM_ARB_COV_EN
  logic [63:0] covmap_q;
  logic [5:0]  cov_idx;
  logic [5:0]  coverage_q;
  logic        cov_hit;

  assign cov_idx = {state_q, g_q, starve, out_ready};
  assign cov_hit = !covmap_q[cov_idx];

  // The map survives reset; only meta_reset clears it.
  always_ff @(posedge clock) begin
    if (meta_reset)
      covmap_q <= '0;
    else if (!reset && cov_hit)
      covmap_q[cov_idx] <= 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      coverage_q <= '0;
    else if (meta_reset)
      coverage_q <= '0;
    else if (cov_hit)
      coverage_q <= coverage_q + 6'd1;
  end

  assign coverage = coverage_q;
`else
  logic unused_meta_reset;
  assign unused_meta_reset = meta_reset;
  assign coverage          = '0;
`endif

endmodule
